// File: rtl/bsg_chip_pkg.sv
// Shared definitions for the chip reset bring-up sequencer: stage indices and FSM state type.
package bsg_chip_pkg;

  localparam int unsigned STAGE_CLK_GEN   = 0;
  localparam int unsigned STAGE_LINK_IO   = 1;
  localparam int unsigned STAGE_LINK_CORE = 2;
  localparam int unsigned STAGE_CT        = 3;
  localparam int unsigned STAGE_ROUTER    = 4;
  localparam int unsigned STAGE_BP        = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RELEASE,
    ST_SETTLE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } seq_state_e;

endpackage

// File: rtl/bsg_chip_reset_seq_counter.sv
// Loadable up/down counter shared by the hold, settle and ready-timeout phases of the sequencer.
module bsg_chip_reset_seq_counter
  import bsg_chip_pkg::*;
#(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic [width_p-1:0] tc_val_i,
  output logic               zero_o,
  output logic               tc_o
);

  logic [width_p-1:0] r_count;

  // Priority: clear, load, increment, decrement.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= load_val_i;
    end else if (inc_i) begin
      r_count <= r_count + width_p'(1);
    end else if (dec_i) begin
      r_count <= r_count - width_p'(1);
    end
  end

  assign zero_o = (r_count == '0);
  assign tc_o   = (r_count == tc_val_i);

endmodule

// File: rtl/bsg_chip_reset_sequencer.sv
// Ordered reset release for the chip's clock domains: hold all, then release stage by stage
// with a settle delay and optional ready handshake per stage.
module bsg_chip_reset_sequencer
  import bsg_chip_pkg::*;
#(
  parameter int unsigned num_stages_p    = 6,
  parameter int unsigned cnt_width_p     = 16,
  parameter int unsigned assert_cycles_p = 64,
  parameter int unsigned timeout_p       = 4096
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   start_i,
  input  logic [num_stages_p*cnt_width_p-1:0]    delay_i,
  input  logic [num_stages_p-1:0]                wait_mask_i,
  input  logic [num_stages_p-1:0]                ready_i,
  output logic [num_stages_p-1:0]                stage_reset_o,
  output logic [$clog2(num_stages_p+1)-1:0]      stage_o,
  output logic                                   done_o,
  output logic                                   error_o,
  output logic [$clog2(num_stages_p)-1:0]        err_stage_o
);

  localparam int unsigned STAGE_W = $clog2(num_stages_p + 1);
  localparam int unsigned ERR_W   = $clog2(num_stages_p);

  seq_state_e                r_state, w_state_nxt;
  logic                      r_start_d;
  logic                      r_start_armed;
  logic [num_stages_p-1:0]   r_stage_reset, w_stage_reset_nxt;
  logic [STAGE_W-1:0]        r_stage, w_stage_nxt;
  logic                      r_done, w_done_nxt;
  logic                      r_error, w_error_nxt;
  logic [ERR_W-1:0]          r_err_stage, w_err_stage_nxt;

  logic                      w_start_edge;
  logic                      w_cnt_clr, w_cnt_load, w_cnt_inc, w_cnt_dec;
  logic                      w_cnt_zero, w_cnt_tc;
  logic [cnt_width_p-1:0]    w_cnt_tc_val;
  logic [cnt_width_p-1:0]    w_cur_delay;
  logic                      w_cur_mask, w_cur_ready;
  logic [num_stages_p-1:0]   w_cur_onehot;
  logic [STAGE_W-1:0]        w_stage_inc;
  logic                      w_last;

  // The armed flag keeps a start level held through reset release from counting as an edge.
  assign w_start_edge = start_i & ~r_start_d & r_start_armed;
  assign w_stage_inc  = r_stage + STAGE_W'(1);
  assign w_last       = (w_stage_inc == STAGE_W'(num_stages_p));
  assign w_cnt_tc_val = (r_state == ST_HOLD) ? cnt_width_p'(assert_cycles_p - 1)
                                             : cnt_width_p'(timeout_p - 1);

  always_comb begin
    w_cur_delay  = '0;
    w_cur_mask   = 1'b0;
    w_cur_ready  = 1'b0;
    w_cur_onehot = '0;
    for (int i = 0; i < int'(num_stages_p); i++) begin
      if (r_stage == STAGE_W'(i)) begin
        w_cur_delay     = delay_i[i*cnt_width_p +: cnt_width_p];
        w_cur_mask      = wait_mask_i[i];
        w_cur_ready     = ready_i[i];
        w_cur_onehot[i] = 1'b1;
      end
    end
  end

  bsg_chip_reset_seq_counter #(
    .width_p (cnt_width_p)
  ) u_counter (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clr_i      (w_cnt_clr),
    .load_i     (w_cnt_load),
    .inc_i      (w_cnt_inc),
    .dec_i      (w_cnt_dec),
    .load_val_i (w_cur_delay),
    .tc_val_i   (w_cnt_tc_val),
    .zero_o     (w_cnt_zero),
    .tc_o       (w_cnt_tc)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state       <= ST_IDLE;
      r_start_d     <= 1'b0;
      r_start_armed <= 1'b0;
      r_stage_reset <= '1;
      r_stage       <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_err_stage   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_start_d     <= start_i;
      r_start_armed <= 1'b1;
      r_stage_reset <= w_stage_reset_nxt;
      r_stage       <= w_stage_nxt;
      r_done        <= w_done_nxt;
      r_error       <= w_error_nxt;
      r_err_stage   <= w_err_stage_nxt;
    end
  end

  // Next state and next registered outputs; a start edge overrides every other transition.
  always_comb begin
    w_state_nxt       = r_state;
    w_stage_reset_nxt = r_stage_reset;
    w_stage_nxt       = r_stage;
    w_done_nxt        = r_done;
    w_error_nxt       = r_error;
    w_err_stage_nxt   = r_err_stage;
    w_cnt_clr         = 1'b0;
    w_cnt_load        = 1'b0;
    w_cnt_inc         = 1'b0;
    w_cnt_dec         = 1'b0;

    if (w_start_edge) begin
      w_state_nxt       = ST_HOLD;
      w_cnt_clr         = 1'b1;
      w_stage_reset_nxt = '1;
      w_stage_nxt       = '0;
      w_done_nxt        = 1'b0;
      w_error_nxt       = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_HOLD: begin
          if (w_cnt_tc) w_state_nxt = ST_RELEASE;
          else          w_cnt_inc   = 1'b1;
        end
        ST_RELEASE: begin
          w_stage_reset_nxt = r_stage_reset & ~w_cur_onehot;
          w_cnt_load        = 1'b1;
          w_state_nxt       = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (!w_cnt_zero) begin
            w_cnt_dec = 1'b1;
          end else if (w_cur_mask) begin
            w_state_nxt = ST_WAIT;
            w_cnt_clr   = 1'b1;
          end else begin
            w_state_nxt = ST_NEXT;
          end
        end
        ST_WAIT: begin
          if (w_cur_ready) begin
            w_state_nxt = ST_NEXT;
          end else if (w_cnt_tc) begin
            w_state_nxt     = ST_ERROR;
            w_error_nxt     = 1'b1;
            w_err_stage_nxt = ERR_W'(r_stage);
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_NEXT: begin
          w_stage_nxt = w_stage_inc;
          if (w_last) begin
            w_state_nxt       = ST_DONE;
            w_done_nxt        = 1'b1;
            w_stage_reset_nxt = '0;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end
        ST_DONE: ;
        ST_ERROR: ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign stage_reset_o = r_stage_reset;
  assign stage_o       = r_stage;
  assign done_o        = r_done;
  assign error_o       = r_error;
  assign err_stage_o   = r_err_stage;

endmodule

// File: tb/tb_bsg_chip_reset_sequencer.sv
// Directed bench for the reset sequencer: release timing, ready handshake, timeout, restart, async reset.
module tb_bsg_chip_reset_sequencer;

  localparam int unsigned NS = 6;
  localparam int unsigned CW = 16;
  localparam logic [5:0]  ALL = 6'h3f;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [NS*CW-1:0]  delay;
  logic [NS-1:0]     wait_mask;
  logic [NS-1:0]     ready;
  logic [NS-1:0]     stage_reset;
  logic [2:0]        stage;
  logic              done;
  logic              error;
  logic [2:0]        err_stage;

  int checks;
  int failures;
  int dly [NS];

  bsg_chip_reset_sequencer dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .start_i       (start),
    .delay_i       (delay),
    .wait_mask_i   (wait_mask),
    .ready_i       (ready),
    .stage_reset_o (stage_reset),
    .stage_o       (stage),
    .done_o        (done),
    .error_o       (error),
    .err_stage_o   (err_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2,
                         input int d3, input int d4, input int d5);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3; dly[4] = d4; dly[5] = d5;
    for (int k = 0; k < int'(NS); k++) delay[k*CW +: CW] = CW'(dly[k]);
  endtask

  // Produce a 0->1 on start; one cycle later everything is back in reset and HOLD begins.
  task automatic do_start();
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    check("start_resets", 32'(stage_reset), 32'(ALL));
    check("start_stage", 32'(stage), 32'd0);
    check("start_done", 32'(done), 32'd0);
    check("start_error", 32'(error), 32'd0);
  endtask

  task automatic step_release(input int dd, input logic [5:0] prev, input logic [5:0] nxt,
                              input logic [2:0] stg);
    if (dd > 1) begin
      tick(dd - 1);
      check("pre_release", 32'(stage_reset), 32'(prev));
    end
    tick(1);
    check("release", 32'(stage_reset), 32'(nxt));
    check("release_stage", 32'(stage), 32'(stg));
  endtask

  // Stage 0 releases 65 cycles after the start edge; each later stage delay+3 after the previous.
  task automatic release_stages(input int n);
    for (int k = 0; k < n; k++) begin
      int dd;
      logic [5:0] pv;
      logic [5:0] nv;
      dd = (k == 0) ? 65 : dly[k-1] + 3;
      pv = ALL << k;
      nv = ALL << (k + 1);
      step_release(dd, pv, nv, 3'(k));
    end
  endtask

  task automatic finish_done();
    tick(dly[5] + 1);
    check("done_early", 32'(done), 32'd0);
    check("stage_before_done", 32'(stage), 32'd5);
    tick(1);
    check("done", 32'(done), 32'd1);
    check("done_stage", 32'(stage), 32'd6);
    check("done_resets", 32'(stage_reset), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    wait_mask = '0;
    ready     = '0;
    set_dly(0, 0, 0, 0, 0, 0);
    tick(2);
    check("rst_resets", 32'(stage_reset), 32'(ALL));
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_stage", 32'(err_stage), 32'd0);
    reset_n = 1'b1;
    tick(3);

    // 1: zero delays, no waits
    do_start();
    release_stages(6);
    finish_done();

    // 2: mixed delays, restart from DONE
    set_dly(10, 20, 0, 5, 1, 3);
    do_start();
    release_stages(6);
    finish_done();

    // 3: stage 2 waits for ready, raised 50 cycles into WAIT
    set_dly(0, 0, 0, 0, 0, 0);
    wait_mask = 6'b000100;
    do_start();
    release_stages(3);
    tick(51);
    ready = 6'b000100;
    step_release(3, ALL << 3, ALL << 4, 3'd3);
    step_release(3, ALL << 4, ALL << 5, 3'd4);
    step_release(3, ALL << 5, 6'd0, 3'd5);
    finish_done();
    ready = '0;

    // 4: ready never arrives -> timeout after 4096 WAIT cycles
    do_start();
    release_stages(3);
    tick(4096);
    check("err_early", 32'(error), 32'd0);
    tick(1);
    check("err", 32'(error), 32'd1);
    check("err_stage", 32'(err_stage), 32'd2);
    check("err_resets", 32'(stage_reset), 32'h38);
    check("err_done", 32'(done), 32'd0);
    tick(5);
    check("err_sticky", 32'(error), 32'd1);
    do_start();

    // 5: restart while stage 3 is settling, then complete
    wait_mask = '0;
    set_dly(10, 20, 0, 5, 1, 3);
    do_start();
    release_stages(4);
    tick(1);
    do_start();
    release_stages(6);
    finish_done();

    // 6: async reset mid-WAIT with start held high
    set_dly(0, 0, 0, 0, 0, 0);
    wait_mask = 6'b000100;
    do_start();
    release_stages(3);
    tick(10);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_resets", 32'(stage_reset), 32'(ALL));
    check("arst_stage", 32'(stage), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    tick(2);
    #2;
    reset_n = 1'b1;
    tick(100);
    check("no_level_start", 32'(stage_reset), 32'(ALL));
    check("no_level_stage", 32'(stage), 32'd0);
    wait_mask = '0;
    do_start();
    release_stages(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
